// File: rtl/spi_count_sender_pkg.sv
// Shared definitions for the spi_count_sender block.
//   spi_state_t  : frame sequencer states (IDLE -> LEAD -> XFER -> TRAIL)
//   SPI_DATA_W   : default counter / frame width in bits
//   SPI_CLK_DIV  : default clk_100 cycles per SCLK half-period
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } spi_state_t;

  localparam int SPI_DATA_W  = 8;
  localparam int SPI_CLK_DIV = 4;

endpackage

// File: rtl/spi_count_sender_if.sv
// Signal bundle between spi_count_sender and its environment.
//   next_count, start_send : synchronized button levels into the block
//   spi_miso               : serial data from the SPI slave
//   spi_sclk/mosi/cs_n     : SPI mode-0 master outputs
//   busy, done             : frame in progress / one-cycle end-of-frame pulse
//   count_o, rx_data       : press counter and last received byte
//   state                  : frame sequencer state, for observation only
// Handshake: start_send has no ready; a rising edge is accepted only while
// busy is low and is silently dropped otherwise. done marks the single cycle
// in which rx_data is updated and busy falls.
interface spi_count_sender_if #(
  parameter int DATA_W = spi_pkg::SPI_DATA_W
) ();
  logic              next_count;
  logic              start_send;
  logic              spi_miso;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_cs_n;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] count_o;
  logic [DATA_W-1:0] rx_data;
  spi_pkg::spi_state_t state;

  // The block is the SPI master.
  modport master (
    input  next_count, start_send, spi_miso,
    output spi_sclk, spi_mosi, spi_cs_n, busy, done, count_o, rx_data, state
  );

  modport slave (
    output next_count, start_send, spi_miso,
    input  spi_sclk, spi_mosi, spi_cs_n, busy, done, count_o, rx_data, state
  );
endinterface

// File: rtl/spi_count_sender_rise_detect.sv
// Rising-edge detector for an already-synchronized level.
//   clk_100 : system clock
//   s_rst   : synchronous active-high reset
//   i_level : input level
//   o_event : high for the cycle in which i_level is high and was low the
//             cycle before
// The history register resets to 1 so a level held high through reset does
// not produce a spurious event.
module rise_detect (
  input  logic clk_100,
  input  logic s_rst,
  input  logic i_level,
  output logic o_event
);

  logic r_prev;

  always_ff @(posedge clk_100) begin
    if (s_rst) r_prev <= 1'b1;
    else       r_prev <= i_level;
  end

  assign o_event = i_level & ~r_prev;

endmodule

// File: rtl/spi_count_sender.sv
// Press counter plus SPI mode-0 master that sends a snapshot of the counter,
// MSB first, on each start_send rising edge, and captures the MISO byte.
//   clk_100 : system clock
//   s_rst   : synchronous active-high reset
//   bus     : spi_count_sender_if master modport (buttons, SPI pins, status)
// Frame: cs_n low for CLK_DIV*(2*DATA_W+2) cycles = LEAD + DATA_W SCLK
// pulses of CLK_DIV high + CLK_DIV low + TRAIL.
module spi_count_sender
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DATA_W,
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input logic                  clk_100,
  input logic                  s_rst,
  spi_count_sender_if.master   bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  logic w_cnt_ev;
  logic w_start_ev;

  rise_detect u_cnt_edge (
    .clk_100 (clk_100),
    .s_rst   (s_rst),
    .i_level (bus.next_count),
    .o_event (w_cnt_ev)
  );

  rise_detect u_start_edge (
    .clk_100 (clk_100),
    .s_rst   (s_rst),
    .i_level (bus.start_send),
    .o_event (w_start_ev)
  );

  // Wrapping press counter, live in every state.
  logic [DATA_W-1:0] r_count;

  always_ff @(posedge clk_100) begin
    if (s_rst)         r_count <= '0;
    else if (w_cnt_ev) r_count <= r_count + 1'b1;
  end

  spi_state_t        r_state;
  logic [DIV_W-1:0]  r_div;
  logic [BIT_W-1:0]  r_bits;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_sclk;
  logic              r_mosi;
  logic              r_cs_n;
  logic              r_busy;
  logic              r_done;

  always_ff @(posedge clk_100) begin
    if (s_rst) begin
      r_state   <= IDLE;
      r_div     <= '0;
      r_bits    <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_sclk <= 1'b0;
          if (w_start_ev) begin
            // r_count is the pre-increment value if next_count fires too.
            r_tx    <= r_count;
            r_mosi  <= r_count[DATA_W-1];
            r_div   <= '0;
            r_bits  <= '0;
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= LEAD;
          end
        end

        LEAD: begin
          if (r_div == DIV_LAST) begin
            r_div   <= '0;
            r_state <= XFER;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        XFER: begin
          if (r_div == DIV_LAST) begin
            r_div <= '0;
            if (!r_sclk) begin
              // Rising SCLK: slave data has been stable for a half period.
              r_sclk <= 1'b1;
              r_rx   <= {r_rx[DATA_W-2:0], bus.spi_miso};
            end else begin
              r_sclk <= 1'b0;
              r_bits <= r_bits + 1'b1;
              if (r_bits == BIT_LAST) begin
                // Last bit: leave MOSI as is and close the frame.
                r_state <= TRAIL;
              end else begin
                r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                r_mosi <= r_tx[DATA_W-2];
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        TRAIL: begin
          if (r_div == DIV_LAST) begin
            r_div     <= '0;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_rx_data <= r_rx;
            r_state   <= IDLE;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.spi_sclk = r_sclk;
  assign bus.spi_mosi = r_mosi;
  assign bus.spi_cs_n = r_cs_n;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.count_o  = r_count;
  assign bus.rx_data  = r_rx_data;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_spi_count_sender.sv
module tb_spi_count_sender;
  import spi_pkg::*;

  localparam int DATA_W  = 8;
  localparam int CLK_DIV = 4;
  localparam int FRAME_LEN = CLK_DIV * (2 * DATA_W + 2);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic s_rst;
  always #5 clk = ~clk;

  spi_count_sender_if #(.DATA_W(DATA_W)) bus ();

  spi_count_sender #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
    .clk_100 (clk),
    .s_rst   (s_rst),
    .bus     (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  // Each entry: {expected MOSI byte, expected MISO byte}.
  logic [2*DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- slave model (mode 0, MSB first) ----------------
  logic [DATA_W-1:0] slv_byte = '0;
  int slv_idx = 0;

  always @(negedge bus.spi_cs_n) begin
    slv_idx = DATA_W - 1;
    bus.spi_miso = slv_byte[slv_idx];
  end

  always @(negedge bus.spi_sclk) begin
    if (!bus.spi_cs_n && slv_idx > 0) begin
      slv_idx--;
      bus.spi_miso = slv_byte[slv_idx];
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
  logic in_frame = 1'b0;
  int low_len = 0, pulses = 0, phase = 0, bad = 0;
  logic [DATA_W-1:0] tx_cap = '0;
  logic [2*DATA_W-1:0] e;

  always @(negedge clk) begin
    if (s_rst) begin
      in_frame = 1'b0;
    end else begin
      if (prev_cs && !bus.spi_cs_n) begin
        in_frame = 1'b1; low_len = 0; pulses = 0; phase = 0; bad = 0; tx_cap = '0;
      end
      if (in_frame && !bus.spi_cs_n) begin
        low_len++;
        if (bus.spi_sclk != prev_sclk) begin
          if (bus.spi_sclk) begin
            if (pulses > 0 && phase != CLK_DIV) bad++;
            if (bus.spi_mosi !== prev_mosi) bad++;
            tx_cap = {tx_cap[DATA_W-2:0], bus.spi_mosi};
            pulses++;
          end else if (phase != CLK_DIV) begin
            bad++;
          end
          phase = 1;
        end else begin
          phase++;
        end
      end
      if (bus.done) begin
        check("cs_n_high_at_done", 32'(bus.spi_cs_n), 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("mosi_byte",   32'(tx_cap),      32'(e[2*DATA_W-1:DATA_W]));
          check("rx_data",     32'(bus.rx_data), 32'(e[DATA_W-1:0]));
          check("cs_low_len",  32'(low_len),     32'(FRAME_LEN));
          check("sclk_pulses", 32'(pulses),      32'(DATA_W));
          check("phase_mosi_errors", 32'(bad),   32'd0);
        end
        in_frame = 1'b0;
      end
    end
    prev_cs   = bus.spi_cs_n;
    prev_sclk = bus.spi_sclk;
    prev_mosi = bus.spi_mosi;
  end

  // ---------------- driver tasks ----------------
  logic [DATA_W-1:0] exp_count = '0;

  task automatic pulse_count(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) bus.next_count = 1'b1;
      @(negedge clk) bus.next_count = 1'b0;
      exp_count = exp_count + 1'b1;
    end
  endtask

  task automatic start_frame(input logic [DATA_W-1:0] miso_byte, input bit expect_done);
    @(negedge clk);
    slv_byte = miso_byte;
    bus.start_send = 1'b1;
    if (expect_done) exp_q.push_back({exp_count, miso_byte});
    @(negedge clk) bus.start_send = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int k;
    k = 0;
    while (k < max_cycles) begin
      @(negedge clk);
      if (bus.done) break;
      k++;
    end
    if (k >= max_cycles) check("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk) s_rst = 1'b1;
    repeat (cycles) @(negedge clk);
    s_rst = 1'b0;
    exp_count = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    s_rst = 1'b1;
    bus.next_count = 1'b0;
    bus.start_send = 1'b1;   // held high through reset: must not start a frame
    bus.spi_miso = 1'b0;

    do_reset(3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_after_reset",
            {bus.spi_cs_n, bus.spi_sclk, bus.busy, bus.done, 20'd0, bus.count_o},
            {1'b1, 1'b0, 1'b0, 1'b0, 20'd0, 8'h00});
    end
    check("rx_data_reset", 32'(bus.rx_data), 32'd0);
    check("state_reset", 32'(bus.state), 32'(IDLE));
    @(negedge clk) bus.start_send = 1'b0;
    repeat (3) @(negedge clk);
    check("no_frame_from_held_start", 32'(bus.spi_cs_n), 32'd1);

    // Counting and wrap
    pulse_count(5);
    @(negedge clk);
    check("count_5", 32'(bus.count_o), 32'd5);
    pulse_count(252);
    @(negedge clk);
    check("count_wrap_257", 32'(bus.count_o), 32'd1);
    @(negedge clk) bus.next_count = 1'b1;
    repeat (10) @(negedge clk);
    bus.next_count = 1'b0;
    exp_count = exp_count + 1'b1;
    @(negedge clk);
    check("held_pulse_counts_once", 32'(bus.count_o), 32'd2);

    // Frame carrying 0xA5, slave returns 0x3C
    pulse_count(163);
    @(negedge clk);
    check("count_a5", 32'(bus.count_o), 32'hA5);
    start_frame(8'h3C, 1'b1);
    wait_done(200);
    @(negedge clk);
    check("done_single_cycle", 32'(bus.done), 32'd0);
    check("rx_data_3c", 32'(bus.rx_data), 32'h3C);
    check("busy_after_frame", 32'(bus.busy), 32'd0);

    // Start while busy is dropped; a start in the done cycle is accepted
    start_frame(8'h5A, 1'b1);
    repeat (18) @(negedge clk);
    bus.start_send = 1'b1;
    @(negedge clk) bus.start_send = 1'b0;
    wait_done(200);
    bus.start_send = 1'b1;   // lands in the done cycle
    slv_byte = 8'hC3;
    exp_q.push_back({exp_count, 8'hC3});
    @(negedge clk) bus.start_send = 1'b0;
    check("cs_low_after_done_start", 32'(bus.spi_cs_n), 32'd0);
    wait_done(200);
    repeat (100) @(negedge clk);
    check("no_extra_frame", 32'(bus.spi_cs_n), 32'd1);

    // Simultaneous next_count and start_send
    do_reset(1);
    pulse_count(7);
    @(negedge clk);
    slv_byte = 8'h81;
    bus.next_count = 1'b1;
    bus.start_send = 1'b1;
    exp_q.push_back({8'h07, 8'h81});
    exp_count = exp_count + 1'b1;
    @(negedge clk);
    bus.next_count = 1'b0;
    bus.start_send = 1'b0;
    check("count_after_simultaneous", 32'(bus.count_o), 32'd8);
    wait_done(200);

    // Reset in the middle of a frame: no done, everything back to reset values
    start_frame(8'hFF, 1'b0);
    repeat (28) @(negedge clk);
    check("busy_mid_frame", 32'(bus.busy), 32'd1);
    s_rst = 1'b1;
    @(negedge clk);
    check("mid_reset_outputs",
          {bus.spi_cs_n, bus.spi_sclk, bus.busy, bus.done, 20'd0, bus.count_o},
          {1'b1, 1'b0, 1'b0, 1'b0, 20'd0, 8'h00});
    check("mid_reset_rx_data", 32'(bus.rx_data), 32'd0);
    s_rst = 1'b0;
    exp_count = '0;
    repeat (100) @(negedge clk);
    check("idle_after_mid_reset", 32'(bus.spi_cs_n), 32'd1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_count_sender.md
Name: spi_count_sender

Overview:
- Sits directly downstream of the button handler; consumes its synchronized levels next_count and start_send.
- Keeps a wrapping press counter and transmits a snapshot of it as one SPI mode-0 frame, MSB first, on each start request.
- Captures the MISO byte returned during the frame.
- Single clock domain, clk_100.

Parameters:
DATA_W, 8, counter and frame width in bits (legal range >= 2)
CLK_DIV, 4, clk_100 cycles per SCLK half-period (legal range >= 1)

Ports:
clk_100  in  1  system clock
s_rst  in  1  synchronous, active-high reset
next_count  in  1  synchronized button level; each rising edge increments the counter
start_send  in  1  synchronized button level; each rising edge requests a frame
spi_miso  in  1  SPI data from slave
spi_sclk  out  1  SPI clock, idles low
spi_mosi  out  1  SPI data to slave
spi_cs_n  out  1  active-low chip select
busy  out  1  high while a frame is in progress
done  out  1  one-cycle pulse at frame end
count_o  out  DATA_W  current counter value
rx_data  out  DATA_W  last received MISO byte

Behaviour:
- Interface: one clock, clk_100. Reset s_rst is synchronous and active-high.
- Reset values: spi_sclk=0, spi_mosi=0, spi_cs_n=1, busy=0, done=0, count_o=0, rx_data=0, state=IDLE.
- Reset value of both edge-detector history registers is 1, so an input already held high out of reset produces no event until it goes low and then high again.
- Edge event: ev = in & ~prev, where prev is the input registered one cycle earlier. Events act on the same clock edge on which ev is high.
- Counter:
  - Increments on each next_count event, in every state.
  - Wraps from 2^DATA_W-1 to 0.
- Transmitted value: the shift register loads count_o as it stood before any same-cycle increment. A simultaneous next_count and start_send event therefore sends the old value; count_o shows the new value one cycle later.
- start_send events are accepted only in IDLE. Events while busy are dropped, never queued.
- FSM: IDLE -> LEAD -> XFER -> TRAIL -> IDLE.
  - IDLE: cs_n=1, sclk=0. A start event loads tx_shift and clears the divider and bit counters. Next state LEAD; cs_n=0 and busy=1 from the following cycle. mosi=tx MSB from that cycle.
  - LEAD: hold for CLK_DIV cycles, then XFER.
  - XFER: the divider counts 0..CLK_DIV-1. At terminal count sclk toggles.
    - Rising toggle: sample spi_miso into rx_shift (LSB-in).
    - Falling toggle: shift tx; mosi takes the next bit.
    - After the DATA_W-th falling toggle (sclk back to 0, mosi unchanged), go to TRAIL.
  - TRAIL: hold for CLK_DIV cycles, then IDLE.
    - On the transition to IDLE, cs_n=1, busy=0, done=1 for exactly that one cycle, and rx_data<=rx_shift.
- Frame timing: cs_n is low for CLK_DIV*(2*DATA_W+2) cycles; default 4*18 = 72 cycles. Exactly DATA_W SCLK pulses; each high and low phase lasts CLK_DIV cycles.
- A start event in the cycle done is high is accepted normally, since the block is already IDLE. The minimum cs_n high gap is 1 cycle.
- Reset mid-frame: on the next edge all outputs return to reset values. No done pulse. rx_data=0.
- MOSI holds its value while cs_n is high after a frame; contents are don't-care.

Decomposition:
- Shared package spi_pkg holds:
  - state enum spi_state_t {IDLE, LEAD, XFER, TRAIL};
  - default constants SPI_DATA_W=8 and SPI_CLK_DIV=4.
- One natural sub-module, rise_detect: a registered rising-edge detector with a reset-to-1 history register. It is instantiated twice, for next_count and start_send.
- Counter, divider and shift logic stay in the top module.

Test Plan:
- Reset then idle: hold s_rst 3 cycles, release -> cs_n=1, sclk=0, busy=0, count_o=0 for 20 cycles. Same result if start_send is held high through reset.
- Counting/wrap: 5 next_count pulses -> count_o=5. Total 257 pulses -> count_o=1. A pulse held high 10 cycles counts once.
- Frame: count_o=0xA5, spi_miso driven by a slave model returning 0x3C, one start_send rise ->
  - cs_n low 72 cycles, exactly 8 sclk pulses of 4+4 cycles;
  - mosi bits 1,0,1,0,0,1,0,1 stable across each rising edge;
  - done pulses once as cs_n rises; rx_data=0x3C.
- Busy drop: second start_send rise 20 cycles into the frame -> no extra frame, cs_n stays low exactly 72 cycles. A new rise after done starts a second frame.
- Simultaneous: count_o=7, next_count and start_send rise on the same cycle -> frame carries 0x07, count_o=8.
- Mid-frame reset: assert s_rst at cycle 30 of a frame -> next edge cs_n=1, sclk=0, busy=0, done never pulses, count_o=0, rx_data=0.
